// File: rtl/player_count_pkg.sv
// Shared types for the player count controller: FSM states, operations
// and the request-vector priority decode.
package player_count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTION = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_CLR  = 2'd3
    } op_t;

    // v = {clr, down, up}; clr wins, up together with down cancels out.
    function automatic op_t decode_op(input logic [2:0] v);
        if (v[2])
            return OP_CLR;
        else if (v[1] && v[0])
            return OP_NONE;
        else if (v[0])
            return OP_INC;
        else if (v[1])
            return OP_DEC;
        else
            return OP_NONE;
    endfunction

endpackage

// File: rtl/player_count_ctrl_timer.sv
// pc_timer: loadable up-counter; done is high while the count equals TERM.
module pc_timer #(
    parameter int          W    = 16,
    parameter logic [W-1:0] TERM = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (en)
            value <= value + 1'b1;
    end

    assign done = (value == TERM);

endmodule

// File: rtl/player_count_ctrl.sv
// Debounced up/down/clear player counter with saturation.
// Optional auto-repeat while up or down is held: PLAYER_COUNT_AUTO_REPEAT_EN.
module player_count_ctrl
    import player_count_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int COUNT_W         = 4,
    parameter int MIN_COUNT       = 1,
    parameter int MAX_COUNT       = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up,
    input  logic               down,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               inc_evt,
    output logic               dec_evt,
    output logic               clr_evt,
    output logic               at_min,
    output logic               at_max,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam logic [COUNT_W-1:0] MIN_V = COUNT_W'(MIN_COUNT);
    localparam logic [COUNT_W-1:0] MAX_V = COUNT_W'(MAX_COUNT);

    state_t     state;
    logic [2:0] v;
    logic [2:0] v_q;
    logic       st_load, st_en, st_done;

    assign v         = {clr, down, up};
    assign dbg_state = state;

    // One timer serves both press settling and release debounce.
    always_comb begin
        st_load = 1'b0;
        st_en   = 1'b0;
        case (state)
            IDLE:    st_load = 1'b1;
            SETTLE:  st_en   = (v == v_q) && !st_done;
            ACTION:  st_load = 1'b1;
            HOLD: begin
                if (v != 3'b000)
                    st_load = 1'b1;
                else
                    st_en = !st_done;
            end
            default: st_load = 1'b1;
        endcase
    end

    pc_timer #(
        .W    (16),
        .TERM (16'(DEBOUNCE_CYCLES - 1))
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (st_load),
        .load_val (16'd0),
        .en       (st_en),
        .done     (st_done)
    );

`ifdef PLAYER_COUNT_AUTO_REPEAT_EN
    logic        rep_cancel, rep_ok, rp_load, rp_en, rp_done;
    logic [23:0] rp_val;

    assign rep_ok  = !rep_cancel && (v == v_q) && (v_q == 3'b001 || v_q == 3'b010);
    assign rp_load = (state == IDLE) || (state == ACTION);
    // ACTION itself is the first cycle of the next repeat interval.
    assign rp_val  = (state == ACTION) ? 24'd1 : 24'd0;
    assign rp_en   = (state == HOLD) && rep_ok && !rp_done;

    pc_timer #(
        .W    (24),
        .TERM (24'(REPEAT_CYCLES - 1))
    ) u_repeat_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rp_load),
        .load_val (rp_val),
        .en       (rp_en),
        .done     (rp_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            v_q     <= 3'b000;
            count   <= MIN_V;
            at_min  <= 1'b1;
            at_max  <= 1'b0;
            inc_evt <= 1'b0;
            dec_evt <= 1'b0;
            clr_evt <= 1'b0;
            busy    <= 1'b0;
`ifdef PLAYER_COUNT_AUTO_REPEAT_EN
            rep_cancel <= 1'b0;
`endif
        end else begin
            inc_evt <= 1'b0;
            dec_evt <= 1'b0;
            clr_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (v != 3'b000) begin
                        state <= SETTLE;
                        v_q   <= v;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (v != v_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (st_done) begin
                        state <= ACTION;
                    end
                end
                ACTION: begin
                    case (decode_op(v_q))
                        OP_CLR: begin
                            count   <= MIN_V;
                            at_min  <= 1'b1;
                            at_max  <= 1'b0;
                            clr_evt <= 1'b1;
                        end
                        OP_INC: begin
                            if (count != MAX_V) begin
                                count   <= count + 1'b1;
                                at_min  <= 1'b0;
                                at_max  <= (count == MAX_V - 1'b1);
                                inc_evt <= 1'b1;
                            end
                        end
                        OP_DEC: begin
                            if (count != MIN_V) begin
                                count   <= count - 1'b1;
                                at_max  <= 1'b0;
                                at_min  <= (count == MIN_V + 1'b1);
                                dec_evt <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    state <= HOLD;
`ifdef PLAYER_COUNT_AUTO_REPEAT_EN
                    rep_cancel <= 1'b0;
`endif
                end
                HOLD: begin
`ifdef PLAYER_COUNT_AUTO_REPEAT_EN
                    if (v != v_q)
                        rep_cancel <= 1'b1;
                    if (rep_ok && rp_done)
                        state <= ACTION;
                    else
`endif
                    if (v == 3'b000 && st_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_count_ctrl.sv
// Scoreboard bench for player_count_ctrl: a press-level reference model
// predicts each event (edge, type, new count); a monitor checks them.
module tb_player_count_ctrl;

    localparam int N    = 4;
    localparam int R    = 8;
    localparam int W    = 4;
    localparam int MINC = 1;
    localparam int MAXC = 9;
    localparam int EW   = 16 + 3 + W;
    localparam int GAP  = 2 * N + 4;
`ifdef PLAYER_COUNT_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         up = 1'b0, down = 1'b0, clr = 1'b0;
    logic [W-1:0] count;
    logic         inc_evt, dec_evt, clr_evt, at_min, at_max, busy;
    logic [1:0]   dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int model_count = MINC;
    int cyc = 0;

    player_count_ctrl #(
        .DEBOUNCE_CYCLES (N),
        .REPEAT_CYCLES   (R),
        .COUNT_W         (W),
        .MIN_COUNT       (MINC),
        .MAX_COUNT       (MAXC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up),
        .down      (down),
        .clr       (clr),
        .count     (count),
        .inc_evt   (inc_evt),
        .dec_evt   (dec_evt),
        .clr_evt   (clr_evt),
        .at_min    (at_min),
        .at_max    (at_max),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock/reset block: cyc holds the index of the most recent rising edge
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one operation of request v, visible after edge e.
    task automatic model_op(input logic [2:0] v, input int e);
        logic [2:0] evt;
        evt = 3'b000;
        if (v[2]) begin
            model_count = MINC;
            evt = 3'b100;
        end else if (v[1] && v[0]) begin
            evt = 3'b000;
        end else if (v[0] && model_count < MAXC) begin
            model_count++;
            evt = 3'b001;
        end else if (v[1] && !v[0] && model_count > MINC) begin
            model_count--;
            evt = 3'b010;
        end
        if (evt != 3'b000)
            exp_q.push_back({16'(e), evt, W'(model_count)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " count"}, count, model_count);
        check({tag, " at_min"}, at_min, model_count == MINC);
        check({tag, " at_max"}, at_max, model_count == MAXC);
    endtask

    // Hold v for len sampled edges, release for gap, then check quiescent state.
    task automatic press(input logic [2:0] v, input int len, input int gap, input string tag);
        int e0;
        e0 = cyc + 1;
        if (len >= N + 1) begin
            model_op(v, e0 + N + 1);
            if (REP_EN && (v == 3'b001 || v == 3'b010))
                for (int k = 1; N + k * R <= len - 1; k++)
                    model_op(v, e0 + N + 1 + k * R);
        end
        {clr, down, up} = v;
        tick(len);
        {clr, down, up} = 3'b000;
        tick(gap);
        check_idle(tag);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (inc_evt || dec_evt || clr_evt) begin
            logic [EW-1:0] got, exp;
            got = {16'(cyc), clr_evt, dec_evt, inc_evt, count};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got edge %0d evt %b count %0d, expected none",
                         cyc, got[W+2:W], count);
            end else begin
                exp = exp_q.pop_front();
                if (got != exp) begin
                    n_errors++;
                    $display("FAIL event: got edge %0d evt %b count %0d, expected edge %0d evt %b count %0d",
                             got[EW-1:W+3], got[W+2:W], got[W-1:0],
                             exp[EW-1:W+3], exp[W+2:W], exp[W-1:0]);
                end
            end
        end
    end

    initial begin
        tick(3);
        check("reset count", count, MINC);
        check("reset at_min", at_min, 1);
        check("reset at_max", at_max, 0);
        check("reset busy", busy, 0);
        check("reset events", {inc_evt, dec_evt, clr_evt}, 0);
        rst_n = 1'b1;
        tick(1);

        press(3'b001, 20, GAP, "long_up");
        for (int i = 0; i < 7; i++)
            press(3'b001, 2, 2, "toggle");

        for (int i = 0; i < 8; i++)
            press(3'b001, N + 2, GAP, "to_max");
        press(3'b001, N + 2, GAP, "sat_max");
        press(3'b100, N + 2, GAP, "clr");
        press(3'b010, N + 2, GAP, "sat_min");

        for (int i = 0; i < 4; i++)
            press(3'b001, N + 2, GAP, "to_5");
        press(3'b111, N + 2, GAP, "all_three");
        for (int i = 0; i < 4; i++)
            press(3'b001, N + 2, GAP, "to_5b");
        press(3'b011, N + 2, GAP, "up_down");
        press(3'b010, N + 2, GAP, "down");
        press(3'b100, N + 2, GAP, "clr_b");
        press(3'b100, N + 2, GAP, "clr_at_min");

        // reset during SETTLE with up held through deassertion
        press(3'b001, N + 2, GAP, "pre_rst");
        up = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst busy", busy, 0);
        check("mid_rst count", count, MINC);
        rst_n = 1'b1;
        model_count = MINC;
        model_op(3'b001, cyc + 1 + N + 1);
        tick(N + 3);
        up = 1'b0;
        tick(GAP);
        check_idle("post_rst");

        press(3'b100, 40, GAP, "clr_long");
        press(3'b001, 34, GAP, "up_repeat");
        press(3'b010, 30, GAP, "down_repeat");

        for (int i = 0; i < 30; i++)
            press(3'($urandom_range(1, 7)), $urandom_range(1, N + 3 + 2 * R), GAP, "random");

        tick(4);
        check("leftover expected events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
